// File: rtl/mac_pipe_if.sv
// Sample/result bundle of the pipelined multiply-accumulate unit.
// The master drives samples and observes results; the MAC itself is the slave.
interface mac_pipe_if #(
    parameter int A_WIDTH   = 32,
    parameter int B_WIDTH   = 32,
    parameter int ACC_WIDTH = 64
);
    logic                 in_valid;
    logic                 clear;
    logic                 signed_mode;
    logic [A_WIDTH-1:0]   a_in;
    logic [B_WIDTH-1:0]   b_in;
    logic [ACC_WIDTH-1:0] acc_out;
    logic                 out_valid;
    logic                 overflow;

    modport master (
        output in_valid, clear, signed_mode, a_in, b_in,
        input  acc_out, out_valid, overflow
    );

    modport slave (
        input  in_valid, clear, signed_mode, a_in, b_in,
        output acc_out, out_valid, overflow
    );
endinterface

// File: rtl/mac_pipe.sv
// Three-stage pipelined multiply-accumulate with per-sample signed/unsigned mode,
// in-band clear and a sticky overflow flag. Optional clamping: MAC_PIPE_SATURATE_EN.
module mac_pipe #(
    parameter int A_WIDTH   = 32,
    parameter int B_WIDTH   = 32,
    parameter int ACC_WIDTH = 64
) (
    input logic       clk,
    input logic       rst,
    mac_pipe_if.slave mac
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    generate
        if (ACC_WIDTH < P_WIDTH) begin : g_width_check
            $error("mac_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
    endgenerate

`ifdef MAC_PIPE_SATURATE_EN
    function automatic logic [ACC_WIDTH-1:0] saturate(
        input logic [ACC_WIDTH-1:0] wrapped,
        input logic                 ovf,
        input logic                 is_signed,
        input logic                 addend_neg
    );
        logic [ACC_WIDTH-1:0] smax;
        logic [ACC_WIDTH-1:0] smin;
        smax = {1'b0, {(ACC_WIDTH-1){1'b1}}};
        smin = {1'b1, {(ACC_WIDTH-1){1'b0}}};
        if (!ovf)
            return wrapped;
        else if (!is_signed)
            return '1;
        else if (addend_neg)
            return smin;
        else
            return smax;
    endfunction
`endif

    // ---- S1: sample capture ----
    logic                     vld_p0_q, clr_p0_q, mode_p0_q;
    logic signed [A_WIDTH-1:0] a_p0_q;
    logic signed [B_WIDTH-1:0] b_p0_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0_q  <= 1'b0;
            clr_p0_q  <= 1'b0;
            mode_p0_q <= 1'b0;
            a_p0_q    <= '0;
            b_p0_q    <= '0;
        end else begin
            vld_p0_q  <= mac.in_valid;
            clr_p0_q  <= mac.clear;
            mode_p0_q <= mac.signed_mode;
            // Operands only load with a valid sample so idle-bus garbage never reaches the multiplier.
            if (mac.in_valid) begin
                a_p0_q <= mac.a_in;
                b_p0_q <= mac.b_in;
            end
        end
    end

    // ---- S2: product, extended to accumulator width by mode ----
    logic [P_WIDTH-1:0]          a_ext, b_ext, prod;
    logic signed [ACC_WIDTH-1:0] prod_d;
    logic                        vld_p1_q, clr_p1_q, mode_p1_q;
    logic signed [ACC_WIDTH-1:0] prod_p1_q;

    // Low P_WIDTH bits of the product are exact for both modes once operands are extended correctly.
    always_comb begin
        a_ext  = mode_p0_q ? P_WIDTH'(a_p0_q) : P_WIDTH'($unsigned(a_p0_q));
        b_ext  = mode_p0_q ? P_WIDTH'(b_p0_q) : P_WIDTH'($unsigned(b_p0_q));
        prod   = a_ext * b_ext;
        prod_d = mode_p0_q ? ACC_WIDTH'($signed(prod)) : ACC_WIDTH'(prod);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1_q  <= 1'b0;
            clr_p1_q  <= 1'b0;
            mode_p1_q <= 1'b0;
            prod_p1_q <= '0;
        end else begin
            vld_p1_q  <= vld_p0_q;
            clr_p1_q  <= clr_p0_q;
            mode_p1_q <= mode_p0_q;
            if (vld_p0_q)
                prod_p1_q <= prod_d;
        end
    end

    // ---- S3: accumulate ----
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                        ovf_q, ovf_d;
    logic                        out_vld_q, out_vld_d;
    logic [ACC_WIDTH:0]          sum;
    logic                        add_ovf;
    logic [ACC_WIDTH-1:0]        add_res;

    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, prod_p1_q};
        if (mode_p1_q)
            add_ovf = (acc_q[ACC_WIDTH-1] == prod_p1_q[ACC_WIDTH-1]) &&
                      (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]);
        else
            add_ovf = sum[ACC_WIDTH];
`ifdef MAC_PIPE_SATURATE_EN
        add_res = saturate(sum[ACC_WIDTH-1:0], add_ovf, mode_p1_q, acc_q[ACC_WIDTH-1]);
`else
        add_res = sum[ACC_WIDTH-1:0];
`endif

        acc_d     = acc_q;
        ovf_d     = ovf_q;
        out_vld_d = vld_p1_q;
        if (vld_p1_q && clr_p1_q) begin
            acc_d = prod_p1_q;
            ovf_d = 1'b0;
        end else if (vld_p1_q) begin
            acc_d = add_res;
            ovf_d = ovf_q | add_ovf;
        end else if (clr_p1_q) begin
            acc_d = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            out_vld_q <= 1'b0;
        end else begin
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            out_vld_q <= out_vld_d;
        end
    end

    assign mac.acc_out   = acc_q;
    assign mac.out_valid = out_vld_q;
    assign mac.overflow  = ovf_q;

endmodule

// File: tb/tb_mac_pipe.sv
// Directed bench for mac_pipe (default 32x32 -> 64 configuration).
module tb_mac_pipe;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    mac_pipe_if #(.A_WIDTH(32), .B_WIDTH(32), .ACC_WIDTH(64)) bus ();

    mac_pipe #(.A_WIDTH(32), .B_WIDTH(32), .ACC_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .mac (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic v, input logic c, input logic m,
                        input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.in_valid    = v;
        bus.clear       = c;
        bus.signed_mode = m;
        bus.a_in        = a;
        bus.b_in        = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] exp_u2, exp_s2, exp_s3;
`ifdef MAC_PIPE_SATURATE_EN
        exp_u2 = 64'hFFFF_FFFF_FFFF_FFFF;
        exp_s2 = 64'h7FFF_FFFF_FFFF_FFFF;
        exp_s3 = 64'h7FFF_FFFF_FFFF_FFFF;
`else
        exp_u2 = 64'hFFFF_FFFC_0000_0002;
        exp_s2 = 64'h8000_0000_0000_0000;
        exp_s3 = 64'hC000_0000_0000_0000;
`endif
        bus.in_valid = 0; bus.clear = 0; bus.signed_mode = 0; bus.a_in = 0; bus.b_in = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_acc", bus.acc_out, 64'd0);
        chk("rst_vld", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_ovf", {63'd0, bus.overflow}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Latency: 3 * -4 with clear
        step(1, 1, 1, 32'd3, 32'hFFFF_FFFC);
        chk("lat_vld_e0", {63'd0, bus.out_valid}, 64'd0);
        idle();
        chk("lat_vld_e1", {63'd0, bus.out_valid}, 64'd0);
        idle();
        chk("lat_acc", bus.acc_out, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("lat_vld", {63'd0, bus.out_valid}, 64'd1);
        idle();
        chk("lat_vld_off", {63'd0, bus.out_valid}, 64'd0);

        // Streaming a = 1..10, b = 2
        for (int i = 0; i < 10; i++) begin
            step(1, i == 0, 1, 32'(i + 1), 32'd2);
            if (i >= 2) begin
                chk("stream_vld", {63'd0, bus.out_valid}, 64'd1);
                chk("stream_acc", bus.acc_out, 64'((i - 1) * i));
            end
        end
        idle();
        chk("stream_vld", {63'd0, bus.out_valid}, 64'd1);
        chk("stream_acc9", bus.acc_out, 64'd90);
        idle();
        chk("stream_vld", {63'd0, bus.out_valid}, 64'd1);
        chk("stream_final", bus.acc_out, 64'd110);
        idle();
        chk("stream_vld_off", {63'd0, bus.out_valid}, 64'd0);

        // Unsigned max * max, then repeat without clear
        step(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle();
        chk("uns_acc1", bus.acc_out, 64'hFFFF_FFFE_0000_0001);
        chk("uns_ovf1", {63'd0, bus.overflow}, 64'd0);
        idle();
        chk("uns_acc2", bus.acc_out, exp_u2);
        chk("uns_ovf2", {63'd0, bus.overflow}, 64'd1);

        // Signed (-2^31)^2 three times
        step(1, 1, 1, 32'h8000_0000, 32'h8000_0000);
        step(1, 0, 1, 32'h8000_0000, 32'h8000_0000);
        step(1, 0, 1, 32'h8000_0000, 32'h8000_0000);
        chk("sgn_acc1", bus.acc_out, 64'h4000_0000_0000_0000);
        chk("sgn_ovf1", {63'd0, bus.overflow}, 64'd0);
        idle();
        chk("sgn_acc2", bus.acc_out, exp_s2);
        chk("sgn_ovf2", {63'd0, bus.overflow}, 64'd1);
        idle();
        chk("sgn_acc3", bus.acc_out, exp_s3);
        chk("sgn_ovf3", {63'd0, bus.overflow}, 64'd1);

        // Idle junk must not disturb acc; then clear without valid
        step(0, 0, 1, 32'hDEAD_BEEF, 32'h1234_5678);
        step(0, 1, 0, 32'hCAFE_F00D, 32'h8765_4321);
        chk("clr_vld0", {63'd0, bus.out_valid}, 64'd0);
        idle();
        chk("junk_hold", bus.acc_out, exp_s3);
        chk("clr_ovf_pre", {63'd0, bus.overflow}, 64'd1);
        chk("clr_vld1", {63'd0, bus.out_valid}, 64'd0);
        idle();
        chk("clr_acc", bus.acc_out, 64'd0);
        chk("clr_ovf", {63'd0, bus.overflow}, 64'd0);
        chk("clr_vld2", {63'd0, bus.out_valid}, 64'd0);

        // Reset with two samples in flight
        step(1, 1, 1, 32'd7, 32'd7);
        step(1, 0, 1, 32'd7, 32'd7);
        step(1, 0, 1, 32'd7, 32'd7);
        chk("mid_pre_acc", bus.acc_out, 64'd49);
        bus.in_valid = 0;
        bus.clear    = 0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_acc", bus.acc_out, 64'd0);
        chk("mid_rst_vld", {63'd0, bus.out_valid}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        idle();
        idle();
        chk("mid_flush_acc", bus.acc_out, 64'd0);
        chk("mid_flush_vld", {63'd0, bus.out_valid}, 64'd0);
        step(1, 0, 1, 32'd5, 32'd5);
        idle();
        idle();
        chk("mid_post_acc", bus.acc_out, 64'd25);
        chk("mid_post_vld", {63'd0, bus.out_valid}, 64'd1);
        chk("mid_post_ovf", {63'd0, bus.overflow}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
